// File: rtl/raster_stream_rx.sv
// raster_stream_rx: receives a pixel stream framed by sof/eol markers, recovers
// each pixel's (x,y) raster coordinate and flags framing errors. One registered
// output stage with a valid/ready handshake on both sides.
// Optional feature: define RASTER_RX_ERR_CNT_EN to add a saturating 16-bit
// err_count output that counts cycles carrying an error pulse.
module raster_stream_rx #(
  parameter int WIDTH     = 10,
  parameter int HEIGHT    = 10,
  parameter int DATA_BITS = 8,
  localparam int X_BITS   = $clog2(WIDTH),
  localparam int Y_BITS   = $clog2(HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_sof,
  input  logic                 s_eol,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic [X_BITS-1:0]    m_x,
  output logic [Y_BITS-1:0]    m_y,
  output logic                 m_eof,
  output logic                 err_sof,
  output logic                 err_eol
`ifdef RASTER_RX_ERR_CNT_EN
  ,
  output logic [15:0]          err_count
`endif
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [X_BITS-1:0] X_ZERO = {X_BITS{1'b0}};
  localparam logic [Y_BITS-1:0] Y_ZERO = {Y_BITS{1'b0}};
  localparam logic [X_BITS-1:0] X_ONE  = X_BITS'(1);
  localparam logic [Y_BITS-1:0] Y_ONE  = Y_BITS'(1);
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(HEIGHT - 1);

  state_t              state_r;
  logic [X_BITS-1:0]   ex_r;
  logic [Y_BITS-1:0]   ey_r;

  logic                accept_s;
  logic                emit_s;
  logic                sof_err_s;
  logic                eol_err_s;
  logic [X_BITS-1:0]   pos_x_s;
  logic [Y_BITS-1:0]   pos_y_s;
  logic                last_x_s;
  logic                line_end_s;
  logic                frame_end_s;
  logic [X_BITS-1:0]   next_x_s;
  logic [Y_BITS-1:0]   next_y_s;
  state_t              next_state_s;

  // The output register may take a new beat when it is empty or being drained.
  assign s_ready  = rst && (!m_valid || m_ready);
  assign accept_s = s_valid && s_ready;

  // Decide where an accepted beat lands, whether it is kept and which errors it raises.
  always_comb begin
    emit_s    = 1'b0;
    sof_err_s = 1'b0;
    eol_err_s = 1'b0;
    pos_x_s   = ex_r;
    pos_y_s   = ey_r;
    case (state_r)
      IDLE: begin
        pos_x_s = X_ZERO;
        pos_y_s = Y_ZERO;
        if (s_sof) begin
          emit_s    = accept_s;
          sof_err_s = 1'b0;
        end else begin
          emit_s    = 1'b0;
          sof_err_s = accept_s;
        end
      end
      ACTIVE: begin
        emit_s = accept_s;
        if (s_sof) begin
          // A new frame start always wins: realign to the origin.
          pos_x_s   = X_ZERO;
          pos_y_s   = Y_ZERO;
          sof_err_s = accept_s && ((ex_r != X_ZERO) || (ey_r != Y_ZERO));
        end else begin
          pos_x_s   = ex_r;
          pos_y_s   = ey_r;
          sof_err_s = 1'b0;
        end
        // eol must coincide exactly with the last column of the line.
        eol_err_s = accept_s && (s_eol != (pos_x_s == X_LAST));
      end
      default: begin
        emit_s    = 1'b0;
        sof_err_s = 1'b0;
        eol_err_s = 1'b0;
      end
    endcase
  end

  // Work out the expected position and state following the emitted beat.
  always_comb begin
    last_x_s    = (pos_x_s == X_LAST);
    line_end_s  = last_x_s || s_eol;
    frame_end_s = line_end_s && (pos_y_s == Y_LAST);
    if (frame_end_s) begin
      next_x_s     = X_ZERO;
      next_y_s     = Y_ZERO;
      next_state_s = IDLE;
    end else if (line_end_s) begin
      next_x_s     = X_ZERO;
      next_y_s     = pos_y_s + Y_ONE;
      next_state_s = ACTIVE;
    end else begin
      next_x_s     = pos_x_s + X_ONE;
      next_y_s     = pos_y_s;
      next_state_s = ACTIVE;
    end
  end

  // Framing FSM, position counters, output register stage and error pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      ex_r    <= X_ZERO;
      ey_r    <= Y_ZERO;
      m_valid <= 1'b0;
      m_data  <= {DATA_BITS{1'b0}};
      m_x     <= X_ZERO;
      m_y     <= Y_ZERO;
      m_eof   <= 1'b0;
      err_sof <= 1'b0;
      err_eol <= 1'b0;
    end else begin
      err_sof <= sof_err_s;
      err_eol <= eol_err_s;
      if (emit_s) begin
        state_r <= next_state_s;
        ex_r    <= next_x_s;
        ey_r    <= next_y_s;
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_x     <= pos_x_s;
        m_y     <= pos_y_s;
        m_eof   <= frame_end_s;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end else begin
        // Stalled downstream: everything holds.
        m_valid <= m_valid;
      end
    end
  end

`ifdef RASTER_RX_ERR_CNT_EN
  // Count cycles carrying any error pulse, saturating at full scale.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_count <= 16'h0000;
    end else if ((err_sof || err_eol) && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'h0001;
    end else begin
      err_count <= err_count;
    end
  end
`endif

endmodule

// File: tb/tb_raster_stream_rx.sv
// Self-checking bench for raster_stream_rx (WIDTH=4, HEIGHT=3). A queue-based
// raster model predicts outputs and error pulses every cycle; per-scenario
// literal expectations pin the model to hand-computed results.
module tb_raster_stream_rx;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DB = 8;

  logic          clk     = 1'b0;
  logic          rst     = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_sof   = 1'b0;
  logic          s_eol   = 1'b0;
  logic          m_ready = 1'b1;
  logic [DB-1:0] s_data  = 8'h00;
  logic          s_ready;
  logic          m_valid;
  logic [DB-1:0] m_data;
  logic [1:0]    m_x;
  logic [1:0]    m_y;
  logic          m_eof;
  logic          err_sof;
  logic          err_eol;
`ifdef RASTER_RX_ERR_CNT_EN
  logic [15:0]   err_count;
`endif

  int tests = 0;
  int fails = 0;

  raster_stream_rx #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .s_eol(s_eol),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_x(m_x), .m_y(m_y), .m_eof(m_eof),
    .err_sof(err_sof), .err_eol(err_eol)
`ifdef RASTER_RX_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int eof;
    int data;
  } beat_t;

  beat_t exp_q[$];
  beat_t dut_log[$];
  beat_t b;
  bit    in_frame = 1'b0;
  int    mx = 0;
  int    my = 0;
  bit    exp_es = 1'b0;
  bit    exp_ee = 1'b0;
  bit    ready_exp;
  bit    last_x;
  bit    toggle = 1'b0;
  int    cnt_es = 0;
  int    cnt_ee = 0;
  int    cnt_both = 0;
  bit    prev_stall = 1'b0;
  beat_t prev_out;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic chk_beat(input string name, input int idx, input int ex, input int ey,
                          input int eeof, input int edata);
    if (idx < dut_log.size()) begin
      chk({name, "_x"}, dut_log[idx].x, ex);
      chk({name, "_y"}, dut_log[idx].y, ey);
      chk({name, "_eof"}, dut_log[idx].eof, eeof);
      chk({name, "_data"}, dut_log[idx].data, edata);
    end else begin
      chk({name, "_present"}, dut_log.size(), idx + 1);
    end
  endtask

  // Compare DUT against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    chk("m_valid", int'(m_valid), int'(exp_q.size() > 0));
    if (m_valid && exp_q.size() > 0) begin
      chk("m_data", int'(m_data), exp_q[0].data);
      chk("m_x", int'(m_x), exp_q[0].x);
      chk("m_y", int'(m_y), exp_q[0].y);
      chk("m_eof", int'(m_eof), exp_q[0].eof);
    end
    chk("err_sof", int'(err_sof), int'(exp_es));
    chk("err_eol", int'(err_eol), int'(exp_ee));
    chk("s_ready", int'(s_ready), int'(rst && (exp_q.size() == 0 || m_ready)));

    if (prev_stall) begin
      chk("stall_valid", int'(m_valid), 1);
      chk("stall_data", int'(m_data), prev_out.data);
      chk("stall_x", int'(m_x), prev_out.x);
      chk("stall_y", int'(m_y), prev_out.y);
      chk("stall_eof", int'(m_eof), prev_out.eof);
    end
    prev_stall    = rst && m_valid && !m_ready;
    prev_out.data = int'(m_data);
    prev_out.x    = int'(m_x);
    prev_out.y    = int'(m_y);
    prev_out.eof  = int'(m_eof);

    if (rst && m_valid && m_ready) dut_log.push_back(prev_out);
    if (err_sof) cnt_es++;
    if (err_eol) cnt_ee++;
    if (err_sof && err_eol) cnt_both++;

    if (!rst) begin
      exp_q.delete();
      in_frame = 1'b0;
      mx = 0;
      my = 0;
      exp_es = 1'b0;
      exp_ee = 1'b0;
    end else begin
      ready_exp = (exp_q.size() == 0) || m_ready;
      if (exp_q.size() > 0 && m_ready) b = exp_q.pop_front();
      exp_es = 1'b0;
      exp_ee = 1'b0;
      if (s_valid && ready_exp) begin
        if (!in_frame && !s_sof) begin
          exp_es = 1'b1;
        end else begin
          if (s_sof) begin
            if (in_frame && (mx != 0 || my != 0)) exp_es = 1'b1;
            mx = 0;
            my = 0;
          end
          last_x = (mx == W - 1);
          if (in_frame && (s_eol != last_x)) exp_ee = 1'b1;
          b.x    = mx;
          b.y    = my;
          b.data = int'(s_data);
          b.eof  = int'((last_x || s_eol) && my == H - 1);
          exp_q.push_back(b);
          if (last_x || s_eol) begin
            mx = 0;
            my++;
          end else begin
            mx++;
          end
          if (b.eof != 0) begin
            in_frame = 1'b0;
            mx = 0;
            my = 0;
          end else begin
            in_frame = 1'b1;
          end
        end
      end
    end
  end

  // Downstream ready: steady high, or alternating when toggle is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = toggle ? ~m_ready : 1'b1;
    end
  end

  task automatic send(input logic [7:0] d, input logic sof, input logic eol);
    int  n;
    bit  took;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    s_eol   = eol;
    took    = 1'b0;
    n       = 0;
    while (!took && n < 50) begin
      @(negedge clk);
      took = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) chk("handshake_timeout", 0, 1);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < W * H; i++)
      send(base + 8'(i), (i == 0), ((i % W) == W - 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_stats();
    dut_log.delete();
    cnt_es = 0;
    cnt_ee = 0;
    cnt_both = 0;
  endtask

  initial begin
    // Reset state
    idle(2);
    @(negedge clk);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_m_x", int'(m_x), 0);
    chk("rst_m_y", int'(m_y), 0);
    chk("rst_m_eof", int'(m_eof), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);

    // T1: clean frame
    clear_stats();
    send_frame(8'h10);
    idle(3);
    chk("t1_count", dut_log.size(), 12);
    chk_beat("t1_b0", 0, 0, 0, 0, 8'h10);
    chk_beat("t1_b5", 5, 1, 1, 0, 8'h15);
    chk_beat("t1_b10", 10, 2, 2, 0, 8'h1A);
    chk_beat("t1_b11", 11, 3, 2, 1, 8'h1B);
    chk("t1_err_sof", cnt_es, 0);
    chk("t1_err_eol", cnt_ee, 0);

    // T2: two beats without sof in IDLE are dropped
    clear_stats();
    send(8'hA0, 1'b0, 1'b0);
    send(8'hA1, 1'b0, 1'b0);
    send_frame(8'h20);
    idle(3);
    chk("t2_err_sof", cnt_es, 2);
    chk("t2_count", dut_log.size(), 12);
    chk_beat("t2_b0", 0, 0, 0, 0, 8'h20);
    chk_beat("t2_b11", 11, 3, 2, 1, 8'h2B);

    // T3: early eol at x=1 of line 0
    clear_stats();
    send(8'h30, 1'b1, 1'b0);
    send(8'h31, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send(8'h32 + 8'(i), 1'b0, ((i % 4) == 3));
    idle(3);
    chk("t3_err_eol", cnt_ee, 1);
    chk("t3_err_sof", cnt_es, 0);
    chk("t3_count", dut_log.size(), 10);
    chk_beat("t3_b1", 1, 1, 0, 0, 8'h31);
    chk_beat("t3_b2", 2, 0, 1, 0, 8'h32);
    chk_beat("t3_b9", 9, 3, 2, 1, 8'h39);

    // T4: sof at (2,1) restarts the frame
    clear_stats();
    send(8'h40, 1'b1, 1'b0);
    send(8'h41, 1'b0, 1'b0);
    send(8'h42, 1'b0, 1'b0);
    send(8'h43, 1'b0, 1'b1);
    send(8'h44, 1'b0, 1'b0);
    send(8'h45, 1'b0, 1'b0);
    send(8'h46, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) send(8'h47 + 8'(i), 1'b0, ((i % 4) == 2));
    idle(3);
    chk("t4_err_sof", cnt_es, 1);
    chk("t4_err_eol", cnt_ee, 0);
    chk("t4_count", dut_log.size(), 18);
    chk_beat("t4_b6", 6, 0, 0, 0, 8'h46);
    chk_beat("t4_b7", 7, 1, 0, 0, 8'h47);
    chk_beat("t4_b8", 8, 2, 0, 0, 8'h48);
    chk_beat("t4_b17", 17, 3, 2, 1, 8'h51);

    // T5: m_ready toggling with continuous s_valid
    clear_stats();
    toggle = 1'b1;
    send_frame(8'h60);
    idle(6);
    toggle = 1'b0;
    idle(2);
    chk("t5_count", dut_log.size(), 12);
    for (int i = 0; i < 12; i++)
      chk_beat("t5_b", i, i % 4, i / 4, int'(i == 11), 8'h60 + i);
    chk("t5_errs", cnt_es + cnt_ee, 0);

    // T6: reset mid-frame at expected position (1,1)
    clear_stats();
    send(8'h70, 1'b1, 1'b0);
    send(8'h71, 1'b0, 1'b0);
    send(8'h72, 1'b0, 1'b0);
    send(8'h73, 1'b0, 1'b1);
    send(8'h74, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_m_valid_after_rst", int'(m_valid), 0);
`ifdef RASTER_RX_ERR_CNT_EN
    chk("t6_err_count", int'(err_count), 0);
`endif
    @(posedge clk);
    #1;
    send(8'h7F, 1'b0, 1'b0);
    send_frame(8'h80);
    idle(3);
    chk("t6_err_sof", cnt_es, 1);
    chk("t6_err_eol", cnt_ee, 0);
    chk("t6_count", dut_log.size(), 16);
    chk_beat("t6_b4", 4, 0, 0, 0, 8'h80);
    chk_beat("t6_b5", 5, 1, 0, 0, 8'h81);
    chk_beat("t6_b15", 15, 3, 2, 1, 8'h8B);

    // T7: one beat with both sof and early eol errors
    clear_stats();
    send(8'h90, 1'b1, 1'b0);
    send(8'h91, 1'b0, 1'b0);
    send(8'h92, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) send(8'h93 + 8'(i), 1'b0, ((i % 4) == 3));
    idle(3);
    chk("t7_both", cnt_both, 1);
    chk("t7_err_sof", cnt_es, 1);
    chk("t7_err_eol", cnt_ee, 1);
    chk("t7_count", dut_log.size(), 11);
    chk_beat("t7_b2", 2, 0, 0, 0, 8'h92);
    chk_beat("t7_b3", 3, 0, 1, 0, 8'h93);
    chk_beat("t7_b10", 10, 3, 2, 1, 8'h9A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
